// File: rtl/ex_muldiv_ctrl_pkg.sv
// Shared RISC-V definitions used by the EX-stage multiply/divide sequencer.
//   XLEN            : operand/result width (only 32 is supported)
//   MD_MUL..MD_REMU : RV32M funct3 encodings
//   md_state_e      : sequencer FSM states (IDLE/BUSY/DONE)
//   md_a_signed / md_b_signed / md_is_div : per-op operand interpretation
// Optional feature macro used by the muldiv files: MULDIV_FAST_MUL_EN.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // Operand A is two's complement for MULH, MULHSU, DIV and REM.
    function automatic logic md_a_signed(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    // Operand B is two's complement for MULH, DIV and REM only.
    function automatic logic md_b_signed(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    // funct3[2] separates the divide group from the multiply group.
    function automatic logic md_is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/ex_muldiv_ctrl_if.sv
// EX-stage <-> muldiv sequencer handshake bundle.
//   start_e, op_e, a_e, b_e, flush_e : from EX / hazard unit to the sequencer
//   stall_req, done, result          : from the sequencer back to the pipeline
// master = pipeline side, slave = sequencer side.
interface ex_muldiv_ctrl_if;
    import riscv_pkg::*;

    logic            start_e;
    logic [2:0]      op_e;
    logic [XLEN-1:0] a_e;
    logic [XLEN-1:0] b_e;
    logic            flush_e;
    logic            stall_req;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start_e, op_e, a_e, b_e, flush_e,
        input  stall_req, done, result
    );

    modport slave (
        input  start_e, op_e, a_e, b_e, flush_e,
        output stall_req, done, result
    );

endinterface

// File: rtl/ex_muldiv_ctrl_datapath.sv
// muldiv_datapath: operand/accumulator registers of the RV32M sequencer.
//   load      : latch operand magnitudes, sign flags and op (accept cycle)
//   step      : perform one shift-add / restoring shift-subtract iteration
//   finish    : final iteration; result <= sign-fixed value
//   imm_load  : result <= imm_val (special case) or fast product
//   result    : registered muldiv result, held until the next completion
// MULDIV_FAST_MUL_EN: multiplies resolve through a 33x33 signed multiplier on imm_load.
module muldiv_datapath #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            step,
    input  logic            finish,
    input  logic            imm_load,
    input  logic [XLEN-1:0] imm_val,
    output logic [XLEN-1:0] result
);
    import riscv_pkg::*;

    // Shared accumulator: multiply = {partial high, multiplier},
    // divide = {remainder, dividend/quotient}.
    logic [2*XLEN-1:0] acc_r, acc_nxt_s;
    logic [XLEN-1:0]   opnd_r;
    logic [2:0]        op_r;
    logic              neg_a_r, neg_b_r;
    logic [XLEN-1:0]   result_r;

    logic            a_sgn_s, b_sgn_s, neg_a_s, neg_b_s;
    logic [XLEN-1:0] mag_a_s, mag_b_s;
    logic [XLEN:0]   mul_sum_s, div_shift_s, div_diff_s;

    assign a_sgn_s = md_a_signed(op);
    assign b_sgn_s = md_b_signed(op);
    assign neg_a_s = a_sgn_s && a[XLEN-1];
    assign neg_b_s = b_sgn_s && b[XLEN-1];
    assign mag_a_s = neg_a_s ? ({XLEN{1'b0}} - a) : a;
    assign mag_b_s = neg_b_s ? ({XLEN{1'b0}} - b) : b;

    // Negate product / quotient / remainder according to the latched signs.
    function automatic logic [XLEN-1:0] md_fixup(
        input logic [2:0]        f_op,
        input logic              f_neg_a,
        input logic              f_neg_b,
        input logic [2*XLEN-1:0] f_acc
    );
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quo;
        logic [XLEN-1:0]   rem;
        logic [XLEN-1:0]   res;
        prod = (f_neg_a ^ f_neg_b) ? ({(2*XLEN){1'b0}} - f_acc) : f_acc;
        quo  = (f_neg_a ^ f_neg_b) ? ({XLEN{1'b0}} - f_acc[XLEN-1:0]) : f_acc[XLEN-1:0];
        rem  = f_neg_a ? ({XLEN{1'b0}} - f_acc[2*XLEN-1:XLEN]) : f_acc[2*XLEN-1:XLEN];
        case (f_op)
            MD_MUL:                       res = prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: res = prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              res = quo;
            MD_REM, MD_REMU:              res = rem;
            default:                      res = {XLEN{1'b0}};
        endcase
        return res;
    endfunction

    // One iteration of shift-add multiply or restoring divide.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
        div_shift_s = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
        // remainder < divisor keeps the shifted value below 2*divisor, so bit XLEN
        // of the difference is a clean borrow flag.
        div_diff_s  = div_shift_s - {1'b0, opnd_r};
        acc_nxt_s   = acc_r;
        if (md_is_div(op_r)) begin
            if (!div_diff_s[XLEN]) begin
                acc_nxt_s = {div_diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
            end else begin
                acc_nxt_s = {div_shift_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_nxt_s = {mul_sum_s, acc_r[XLEN-1:1]};
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fa_s, fb_s;
    logic signed [2*XLEN+1:0] fprod_s;
    logic [XLEN-1:0]          fast_res_s;
    assign fa_s       = {a_sgn_s & a[XLEN-1], a};
    assign fb_s       = {b_sgn_s & b[XLEN-1], b};
    assign fprod_s    = fa_s * fb_s;
    assign fast_res_s = (op == MD_MUL) ? fprod_s[XLEN-1:0] : fprod_s[2*XLEN-1:XLEN];
`endif

    // Operand and accumulator registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_r   <= {(2*XLEN){1'b0}};
            opnd_r  <= {XLEN{1'b0}};
            op_r    <= 3'd0;
            neg_a_r <= 1'b0;
            neg_b_r <= 1'b0;
        end else if (load) begin
            // Product is commutative, so both groups use acc = |a|, opnd = |b|.
            acc_r   <= {{XLEN{1'b0}}, mag_a_s};
            opnd_r  <= mag_b_s;
            op_r    <= op;
            neg_a_r <= neg_a_s;
            neg_b_r <= neg_b_s;
        end else if (step) begin
            acc_r   <= acc_nxt_s;
        end
    end

    // Result register: immediate results in the accept cycle, iterative ones on the final step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_r <= {XLEN{1'b0}};
        end else if (imm_load) begin
`ifdef MULDIV_FAST_MUL_EN
            if (!md_is_div(op)) begin
                result_r <= fast_res_s;
            end else begin
                result_r <= imm_val;
            end
`else
            result_r <= imm_val;
`endif
        end else if (finish) begin
            result_r <= md_fixup(op_r, neg_a_r, neg_b_r, acc_nxt_s);
        end
    end

    assign result = result_r;

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: EX-stage RV32M multiply/divide sequencer.
//   clk, reset : clock, asynchronous active-high reset
//   md (slave) : start_e/op_e/a_e/b_e/flush_e in; stall_req/done/result out
// Iterative ops take 33 cycles start-to-done; divide-by-zero and signed overflow
// complete in 1. With MULDIV_FAST_MUL_EN defined, all multiplies complete in 1.
module ex_muldiv_ctrl #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic             clk,
    input  logic             reset,
    ex_muldiv_ctrl_if.slave  md
);
    import riscv_pkg::*;

    localparam int CNT_W = $clog2(XLEN);

    md_state_e        state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             done_r;

    logic            accept_s, is_div_s, div_zero_s, sovf_s, special_s, fast_s;
    logic            imm_load_s, step_s, finish_s;
    logic [XLEN-1:0] special_val_s;

    // start_e is only honoured in IDLE: in BUSY/DONE it is the same held instruction.
    assign accept_s   = (state_r == MD_IDLE) && md.start_e && !md.flush_e;
    assign is_div_s   = md_is_div(md.op_e);
    assign div_zero_s = is_div_s && (md.b_e == {XLEN{1'b0}});
    assign sovf_s     = ((md.op_e == MD_DIV) || (md.op_e == MD_REM)) &&
                        (md.a_e == {1'b1, {(XLEN-1){1'b0}}}) && (md.b_e == {XLEN{1'b1}});
    assign special_s  = div_zero_s || sovf_s;

`ifdef MULDIV_FAST_MUL_EN
    assign fast_s = !is_div_s;
`else
    assign fast_s = 1'b0;
`endif

    assign imm_load_s = accept_s && (special_s || fast_s);
    assign step_s     = (state_r == MD_BUSY) && !md.flush_e;
    assign finish_s   = step_s && (cnt_r == {CNT_W{1'b0}});

    // Architected results for divide-by-zero and signed overflow (op_e[1] selects REM*).
    always_comb begin
        special_val_s = {XLEN{1'b0}};
        if (div_zero_s) begin
            if (md.op_e[1]) begin
                special_val_s = md.a_e;
            end else begin
                special_val_s = {XLEN{1'b1}};
            end
        end else if (sovf_s) begin
            if (md.op_e[1]) begin
                special_val_s = {XLEN{1'b0}};
            end else begin
                special_val_s = {1'b1, {(XLEN-1){1'b0}}};
            end
        end else begin
            special_val_s = {XLEN{1'b0}};
        end
    end

    // Next-state and iteration counter; flush wins in every state.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        if (md.flush_e) begin
            state_nxt_s = MD_IDLE;
        end else begin
            case (state_r)
                MD_IDLE: begin
                    if (accept_s) begin
                        if (special_s || fast_s) begin
                            state_nxt_s = MD_DONE;
                        end else begin
                            cnt_nxt_s   = CNT_W'(XLEN - 1);
                            state_nxt_s = MD_BUSY;
                        end
                    end else begin
                        state_nxt_s = MD_IDLE;
                    end
                end
                MD_BUSY: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_nxt_s = MD_DONE;
                    end else begin
                        cnt_nxt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                MD_DONE: state_nxt_s = MD_IDLE;
                default: state_nxt_s = MD_IDLE;
            endcase
        end
    end

    // State, counter and the Moore done flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= MD_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            done_r  <= (state_nxt_s == MD_DONE);
        end
    end

    muldiv_datapath #(.XLEN(XLEN)) u_dp (
        .clk      (clk),
        .reset    (reset),
        .load     (accept_s),
        .op       (md.op_e),
        .a        (md.a_e),
        .b        (md.b_e),
        .step     (step_s),
        .finish   (finish_s),
        .imm_load (imm_load_s),
        .imm_val  (special_val_s),
        .result   (md.result)
    );

    // Combinational in the start cycle so EX holds the instruction immediately.
    assign md.stall_req = !reset && (accept_s || (state_r == MD_BUSY));
    assign md.done      = done_r;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
module tb_ex_muldiv_ctrl;
    import riscv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    typedef struct {
        string       nm;
        logic [31:0] exp;
        int          start;
        int          lat;
    } sb_t;

    logic clk;
    logic reset;
    int   cyc;
    int   errors;
    int   checks;
    logic [31:0] last_res;
    sb_t  sb_q[$];
    sb_t  mon_e;

    ex_muldiv_ctrl_if mdif();

    ex_muldiv_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .md    (mdif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every done pops one expected completion from the scoreboard.
    always @(negedge clk) begin
        if (!reset && mdif.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk({mon_e.nm, "_result"}, mdif.result, mon_e.exp);
                chk({mon_e.nm, "_latency"}, 32'(cyc - mon_e.start), 32'(mon_e.lat));
            end
        end
    end

    // Issue one op with start_e held (as the stalled EX stage does) until done.
    // Entered and left at posedge+1.
    task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int st_cnt;
        bit seen;
        st_cnt = 0;
        seen = 1'b0;
        sb_q.push_back('{nm, exp, cyc, lat});
        mdif.op_e = op;
        mdif.a_e = a;
        mdif.b_e = b;
        mdif.start_e = 1'b1;
        for (int i = 0; i < lat + 20 && !seen; i++) begin
            @(negedge clk);
            if (mdif.done === 1'b1) begin
                seen = 1'b1;
                chk({nm, "_stall_in_done"}, 32'(mdif.stall_req), 32'd0);
            end else if (mdif.stall_req === 1'b1) begin
                st_cnt++;
            end
            @(posedge clk);
            #1;
        end
        mdif.start_e = 1'b0;
        if (!seen) begin
            chk({nm, "_timeout"}, 32'd1, 32'd0);
            sb_q.delete();
        end else begin
            chk({nm, "_stall_cycles"}, 32'(st_cnt), 32'(lat));
            last_res = exp;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        cyc = 0;
        errors = 0;
        checks = 0;
        last_res = 32'd0;
        reset = 1'b1;
        mdif.start_e = 1'b1;
        mdif.op_e = MD_DIV;
        mdif.a_e = 32'd10;
        mdif.b_e = 32'd3;
        mdif.flush_e = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_stall", 32'(mdif.stall_req), 32'd0);
        chk("reset_done", 32'(mdif.done), 32'd0);
        chk("reset_result", mdif.result, 32'd0);
        mdif.start_e = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_op("mul",     MD_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        run_op("mulhu",   MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        run_op("mulh",    MD_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT);
        run_op("mulhsu",  MD_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, MUL_LAT);
        run_op("div",     MD_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
        run_op("rem",     MD_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
        run_op("divu",    MD_DIVU,   32'd100,        32'd7,         32'd14,        33);
        run_op("remu",    MD_REMU,   32'd100,        32'd7,         32'd2,         33);
        run_op("divu_z",  MD_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1);
        run_op("remu_z",  MD_REMU,   32'd5,          32'd0,         32'd5,         1);
        run_op("div_z",   MD_DIV,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF, 1);
        run_op("rem_z",   MD_REM,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 1);
        run_op("div_ovf", MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf", MD_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1);
        run_op("div_neg", MD_DIV,    32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 33);

        // Flush in cycle 10 of a DIV: no done, result kept, IDLE next.
        mdif.op_e = MD_DIV;
        mdif.a_e = 32'd1000;
        mdif.b_e = 32'd3;
        mdif.start_e = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        mdif.flush_e = 1'b1;
        @(posedge clk);
        #1;
        mdif.flush_e = 1'b0;
        mdif.start_e = 1'b0;
        @(negedge clk);
        chk("flush_stall", 32'(mdif.stall_req), 32'd0);
        chk("flush_done", 32'(mdif.done), 32'd0);
        chk("flush_result", mdif.result, last_res);
        @(posedge clk);
        #1;
        run_op("divu_after_flush", MD_DIVU, 32'd9, 32'd3, 32'd3, 33);

        // Asynchronous reset in the middle of BUSY.
        mdif.op_e = MD_DIV;
        mdif.a_e = 32'd100;
        mdif.b_e = 32'd7;
        mdif.start_e = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midreset_stall", 32'(mdif.stall_req), 32'd0);
        chk("midreset_done", 32'(mdif.done), 32'd0);
        chk("midreset_result", mdif.result, 32'd0);
        mdif.start_e = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        run_op("remu_after_reset", MD_REMU, 32'd100, 32'd7, 32'd2, 33);
        run_op("mul_b2b", MD_MUL, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd9, MUL_LAT);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_ctrl.md
# ex_muldiv_ctrl

Sequencer for RV32M multiply/divide operations issued in the execute stage. The block accepts an M-extension op from the EX stage and runs an iterative shift-add multiplier or shift-subtract divider. While the op runs it raises a stall request to the hazard unit, which freezes fetch, decode and execute. In the completion cycle it presents the result, which the EX result mux routes into the EX/MEM alu_result register.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high; clock clk.
- start_e  in  1  a valid M-op is in EX this cycle (decoded muldiv and not a bubble).
- op_e  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- a_e  in  XLEN  forwarded operand A (post-forwarding-mux rs1 value).
- b_e  in  XLEN  forwarded operand B (post-forwarding-mux rs2 value, never the immediate).
- flush_e  in  1  hazard-unit EX flush; aborts any op.
- stall_req  out  1  to hazard unit; holds F/D/E while high.
- done  out  1  result valid this cycle; EX/MEM captures it at this cycle's edge.
- result  out  XLEN  muldiv result.

## Operation
- FSM states are IDLE, BUSY and DONE. The reset state is IDLE.
- IDLE:
  - If start_e && !flush_e: latch the operand magnitudes, sign flags, op and special-case flags.
  - If a special case applies (see below), or if MUL* with the fast-multiply feature enabled, go to DONE.
  - Otherwise load cnt = XLEN-1 and go to BUSY.
- BUSY: perform one iteration per cycle and decrement cnt. At cnt == 0, perform the final iteration, load result with the sign-fixed value and go to DONE.
- DONE: assert done and return to IDLE. start_e is ignored in DONE, because it still refers to the same instruction.
- flush_e takes precedence in every state: the next state is IDLE, result is unchanged and done is never asserted for the aborted op.
- Signedness:
  - MULH, DIV and REM take both operands as signed. MULHSU takes A signed and B unsigned. MUL, MULHU, DIVU and REMU are unsigned.
  - Iterate on absolute values, then negate at completion:
    - product when the operand signs differ;
    - quotient when the signs differ;
    - remainder when the dividend is negative.
- Multiply: a 2*XLEN accumulator. MUL returns the low word; MULH, MULHSU and MULHU return the high word.
- Divide: restoring algorithm; shift the remainder left and subtract the divisor when nonnegative.
- Special cases are resolved in IDLE with no iteration:
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000; remainder = 0.
- Reset values:
  - state IDLE, cnt 0, result 0, done 0.
  - stall_req is 0 while reset is high.

## Timing
- stall_req = (IDLE && start_e && !flush_e) || BUSY.
  - It is combinational in the start cycle, so EX holds the instruction in the same cycle.
  - It is low in DONE, so the pipeline advances at the end of DONE.
- done is registered, from the state only (Moore output).
- Latency with start in cycle 0:
  - Iterative op: done in cycle 33; stall_req high in cycles 0–32.
  - Special case or fast MUL: done in cycle 1; stall_req high in cycle 0 only.
- Back-to-back M-ops: the second op sees IDLE in the cycle after DONE and starts normally.
- result holds its value after DONE until the next completion.
- Asynchronous reset mid-op returns the block to the reset values immediately.

## Configuration
- MULDIV_FAST_MUL_EN defined: MUL, MULH, MULHSU and MULHU use a single-cycle 33x33 signed multiplier registered into result, with latency 1. Divide ops are unchanged.
- MULDIV_FAST_MUL_EN undefined: all multiplies use the 32-iteration shift-add path, with latency 33.

## Structure
- The shared riscv_pkg package holds:
  - funct3 constants MD_MUL … MD_REMU;
  - the muldiv state enum (IDLE/BUSY/DONE);
  - the XLEN constant.
- One sub-module, muldiv_datapath, holds the accumulator, remainder and divisor registers, the per-iteration add/subtract and the sign fixup. ex_muldiv_ctrl keeps the FSM, cnt, special-case detection and the stall/done outputs.

## Test plan
- MUL a=7, b=0xFFFFFFFD → result 0xFFFFFFEB.
  - Without the macro: done in cycle 33, stall_req high in cycles 0–32.
  - With the macro: done in cycle 1.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH of the same operands → 0x00000000. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM of the same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, each with done in cycle 1. DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM of the same → 0, each with done in cycle 1.
- DIV started, then flush_e in cycle 10:
  - state IDLE in cycle 11, stall_req 0, done never asserted, result unchanged.
  - A new DIVU 9/3 started in cycle 12 gives done with 3 in cycle 45.
- Reset asserted mid-BUSY: stall_req, done and result are 0 immediately. After reset is released, the next op completes with correct latency.
